// File: rtl/fpu_seq.sv
// Issue sequencer between the FP issue stage and the fpu datapath: holds one op on
// the fpu inputs for its opcode latency, then returns the captured result with its tag.
module fpu_seq #(
    parameter int TAG_W    = 5,
    parameter int LAT_ADD  = 3,
    parameter int LAT_MUL  = 2,
    parameter int LAT_DIV  = 8,
    parameter int LAT_SQRT = 8,
    parameter int LAT_SGN  = 1,
    parameter int LAT_CMP  = 1,
    parameter int LAT_CVT  = 2,
    parameter int HAS_DIV  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [31:0]      req_src0,
    input  logic [31:0]      req_src1,
    input  logic [TAG_W-1:0] req_tag,
    output logic [3:0]       fpu_op,
    output logic [31:0]      fpu_src0,
    output logic [31:0]      fpu_src1,
    input  logic [31:0]      fpu_result,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_data,
    output logic [TAG_W-1:0] resp_tag,
    output logic             resp_illegal,
    output logic             busy
);

    function automatic int max_lat();
        int m;
        m = LAT_ADD;
        if (LAT_MUL > m)  m = LAT_MUL;
        if (LAT_DIV > m)  m = LAT_DIV;
        if (LAT_SQRT > m) m = LAT_SQRT;
        if (LAT_SGN > m)  m = LAT_SGN;
        if (LAT_CMP > m)  m = LAT_CMP;
        if (LAT_CVT > m)  m = LAT_CVT;
        return m;
    endfunction

    localparam int MAX_LAT = max_lat();
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Counter is preloaded with LAT-1 so capture happens on the LAT-th edge after accept.
    function automatic logic [CNT_W-1:0] lat_m1(input logic [3:0] op);
        int lat;
        case (op)
            4'd0, 4'd1:        lat = LAT_ADD;
            4'd2:              lat = LAT_MUL;
            4'd3:              lat = LAT_DIV;
            4'd4:              lat = LAT_SQRT;
            4'd5, 4'd6, 4'd7:  lat = LAT_SGN;
            4'd8, 4'd9, 4'd10: lat = LAT_CMP;
            4'd11, 4'd12:      lat = LAT_CVT;
            default:           lat = 1;
        endcase
        return CNT_W'(lat - 1);
    endfunction

    function automatic logic op_legal(input logic [3:0] op);
        logic ok;
        ok = (op <= 4'd12);
        if ((op == 4'd3 || op == 4'd4) && (HAS_DIV == 0)) ok = 1'b0;
        return ok;
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         op_q, op_d;
    logic [31:0]        src0_q, src0_d;
    logic [31:0]        src1_q, src1_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [31:0]        data_q, data_d;
    logic               illegal_q, illegal_d;
    logic               accept;
    logic               req_legal;

    assign accept    = req_valid & req_ready;
    assign req_legal = op_legal(req_op);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) state_d = req_legal ? S_EXEC : S_DONE;
            end
            S_EXEC: begin
                if (cnt_q == '0) state_d = S_DONE;
            end
            S_DONE: begin
                if (resp_ready) begin
                    if (accept) state_d = req_legal ? S_EXEC : S_DONE;
                    else        state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Flush overrides both a pending capture and a same-cycle accept.
        if (flush) state_d = S_IDLE;
    end

    always_comb begin
        req_ready  = ~flush & ((state_q == S_IDLE) | ((state_q == S_DONE) & resp_ready));
        resp_valid = (state_q == S_DONE);
        busy       = (state_q != S_IDLE);
    end

    always_comb begin
        op_d      = op_q;
        src0_d    = src0_q;
        src1_d    = src1_q;
        tag_d     = tag_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        illegal_d = illegal_q;
        if (accept) begin
            op_d      = req_op;
            src0_d    = req_src0;
            src1_d    = req_src1;
            tag_d     = req_tag;
            cnt_d     = lat_m1(req_op);
            data_d    = '0;
            illegal_d = ~req_legal;
        end else if ((state_q == S_EXEC) && !flush) begin
            if (cnt_q == '0) begin
                data_d    = fpu_result;
                illegal_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            op_q      <= '0;
            src0_q    <= '0;
            src1_q    <= '0;
            tag_q     <= '0;
            data_q    <= '0;
            illegal_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            src0_q    <= src0_d;
            src1_q    <= src1_d;
            tag_q     <= tag_d;
            data_q    <= data_d;
            illegal_q <= illegal_d;
        end
    end

    assign fpu_op       = op_q;
    assign fpu_src0     = src0_q;
    assign fpu_src1     = src1_q;
    assign resp_data    = data_q;
    assign resp_tag     = tag_q;
    assign resp_illegal = illegal_q;

endmodule

// File: tb/tb_fpu_seq.sv
// Bench for fpu_seq: one instance without divide support and one with, sharing stimulus.
module tb_fpu_seq;
    localparam int TAG_W = 5;
    localparam int W     = 1 + TAG_W + 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             req_valid = 1'b0;
    logic             resp_ready = 1'b1;
    logic [3:0]       req_op = '0;
    logic [31:0]      req_src0 = '0;
    logic [31:0]      req_src1 = '0;
    logic [TAG_W-1:0] req_tag = '0;
    logic [31:0]      fpu_result = '0;

    logic             req_ready_a, resp_valid_a, resp_illegal_a, busy_a;
    logic [3:0]       fpu_op_a;
    logic [31:0]      fpu_src0_a, fpu_src1_a, resp_data_a;
    logic [TAG_W-1:0] resp_tag_a;
    logic             req_ready_b, resp_valid_b, resp_illegal_b, busy_b;
    logic [3:0]       fpu_op_b;
    logic [31:0]      fpu_src0_b, fpu_src1_b, resp_data_b;
    logic [TAG_W-1:0] resp_tag_b;

    logic             chk_div = 1'b0;
    logic             m_req_ready, m_resp_valid, m_resp_illegal, m_busy;
    logic [3:0]       m_fpu_op;
    logic [31:0]      m_fpu_src0, m_fpu_src1, m_resp_data;
    logic [TAG_W-1:0] m_resp_tag;

    logic [W-1:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    fpu_seq #(.TAG_W(TAG_W), .HAS_DIV(0)) dut_a (
        .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_ready(req_ready_a),
        .req_op(req_op), .req_src0(req_src0), .req_src1(req_src1), .req_tag(req_tag),
        .fpu_op(fpu_op_a), .fpu_src0(fpu_src0_a), .fpu_src1(fpu_src1_a), .fpu_result(fpu_result),
        .resp_valid(resp_valid_a), .resp_ready(resp_ready), .resp_data(resp_data_a),
        .resp_tag(resp_tag_a), .resp_illegal(resp_illegal_a), .busy(busy_a)
    );

    fpu_seq #(.TAG_W(TAG_W), .HAS_DIV(1)) dut_b (
        .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_ready(req_ready_b),
        .req_op(req_op), .req_src0(req_src0), .req_src1(req_src1), .req_tag(req_tag),
        .fpu_op(fpu_op_b), .fpu_src0(fpu_src0_b), .fpu_src1(fpu_src1_b), .fpu_result(fpu_result),
        .resp_valid(resp_valid_b), .resp_ready(resp_ready), .resp_data(resp_data_b),
        .resp_tag(resp_tag_b), .resp_illegal(resp_illegal_b), .busy(busy_b)
    );

    assign m_req_ready    = chk_div ? req_ready_b    : req_ready_a;
    assign m_resp_valid   = chk_div ? resp_valid_b   : resp_valid_a;
    assign m_resp_illegal = chk_div ? resp_illegal_b : resp_illegal_a;
    assign m_busy         = chk_div ? busy_b         : busy_a;
    assign m_fpu_op       = chk_div ? fpu_op_b       : fpu_op_a;
    assign m_fpu_src0     = chk_div ? fpu_src0_b     : fpu_src0_a;
    assign m_fpu_src1     = chk_div ? fpu_src1_b     : fpu_src1_a;
    assign m_resp_data    = chk_div ? resp_data_b    : resp_data_a;
    assign m_resp_tag     = chk_div ? resp_tag_b     : resp_tag_a;

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int tb_lat(input logic [3:0] op);
        if (op <= 4'd1) return 3;
        if (op == 4'd2) return 2;
        if (op <= 4'd4) return 8;
        if (op <= 4'd10) return 1;
        return 2;
    endfunction

    function automatic logic tb_legal(input logic [3:0] op, input logic has_div);
        if (op > 4'd12) return 1'b0;
        if ((op == 4'd3 || op == 4'd4) && !has_div) return 1'b0;
        return 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] tag);
        req_op = op; req_src0 = a; req_src1 = b; req_tag = tag; req_valid = 1'b1;
        n_vec++;
        if (m_req_ready !== 1'b1) begin
            n_err++; $display("FAIL issue_req_ready: got %b expected 1", m_req_ready);
        end
        tick();
        req_valid = 1'b0;
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [TAG_W-1:0] tag, input logic [31:0] res);
        logic legal;
        int lat;
        logic [W-1:0] e;
        legal = tb_legal(op, chk_div);
        lat = tb_lat(op);
        fpu_result = 32'hA5A5_A5A5;
        issue(op, a, b, tag);
        exp_q.push_back(legal ? {1'b0, tag, res} : {1'b1, tag, 32'h0});
        if (legal) begin
            fpu_result = 32'hDEAD_BEEF;
            n_vec++;
            if (m_busy !== 1'b1) begin
                n_err++; $display("FAIL run_busy op=%0d: got %b expected 1", op, m_busy);
            end
            for (int i = 0; i < lat; i++) begin
                n_vec++;
                if (m_resp_valid !== 1'b0) begin
                    n_err++; $display("FAIL run_early_valid op=%0d cyc=%0d: got %b expected 0", op, i, m_resp_valid);
                end
                if (i == lat - 1) begin
                    n_vec++;
                    if ({m_fpu_op, m_fpu_src0, m_fpu_src1} !== {op, a, b}) begin
                        n_err++; $display("FAIL run_fpu_hold: got %h %h %h expected %h %h %h",
                                          m_fpu_op, m_fpu_src0, m_fpu_src1, op, a, b);
                    end
                    fpu_result = res;
                end
                tick();
            end
            fpu_result = 32'hDEAD_BEEF;
        end
        n_vec++;
        if (m_resp_valid !== 1'b1) begin
            n_err++; $display("FAIL run_resp_valid op=%0d: got %b expected 1", op, m_resp_valid);
        end
        e = exp_q.pop_front();
        n_vec++;
        if ({m_resp_illegal, m_resp_tag, m_resp_data} !== e) begin
            n_err++; $display("FAIL run_resp op=%0d: got %h expected %h", op,
                              {m_resp_illegal, m_resp_tag, m_resp_data}, e);
        end
        tick();
        n_vec++;
        if ({m_resp_valid, m_busy} !== 2'b00) begin
            n_err++; $display("FAIL run_idle op=%0d: got %b expected 00", op, {m_resp_valid, m_busy});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        n_vec++;
        if ({fpu_op_a, fpu_src0_a, fpu_src1_a, resp_valid_a, resp_data_a, resp_tag_a, resp_illegal_a, busy_a} !== '0) begin
            n_err++; $display("FAIL reset_outputs: got %h %h %h %b %h %h %b %b expected all 0", fpu_op_a,
                              fpu_src0_a, fpu_src1_a, resp_valid_a, resp_data_a, resp_tag_a, resp_illegal_a, busy_a);
        end
        rst = 1'b0;
        tick();
        n_vec++;
        if ({req_ready_a, req_ready_b, busy_a, busy_b} !== 4'b1100) begin
            n_err++; $display("FAIL reset_ready: got %b expected 1100", {req_ready_a, req_ready_b, busy_a, busy_b});
        end
    endtask

    task automatic test_fmul();
        run_op(4'd2, 32'h4000_0000, 32'h4040_0000, 5'd7, 32'h40C0_0000);
    endtask

    task automatic test_patterns();
        run_op(4'd0, 32'h3F80_0000, 32'h3F80_0000, 5'd1, 32'h4000_0000);
        run_op(4'd1, 32'h4040_0000, 32'h3F80_0000, 5'd2, 32'h4000_0000);
        run_op(4'd5, 32'h3F80_0000, 32'hBF80_0000, 5'd4, 32'hBF80_0000);
        run_op(4'd9, 32'h3F80_0000, 32'h4000_0000, 5'd5, 32'h0000_0001);
        run_op(4'd11, 32'h4120_0000, 32'h0, 5'd30, 32'h0000_000A);
        run_op(4'd12, 32'h0000_0003, 32'h0, 5'd31, 32'h4040_0000);
    endtask

    task automatic test_illegal();
        run_op(4'd14, 32'h1111_1111, 32'h2222_2222, 5'd3, 32'h7777_7777);
        run_op(4'd15, 32'h3333_3333, 32'h4444_4444, 5'd0, 32'h5555_5555);
        run_op(4'd13, 32'h6666_6666, 32'h0, 5'd17, 32'h0);
    endtask

    task automatic test_random();
        logic [3:0] op;
        for (int n = 0; n < 24; n++) begin
            op = 4'($urandom_range(0, 15));
            if (op == 4'd3 || op == 4'd4) op = op + 4'd10;
            run_op(op, $urandom(), $urandom(), TAG_W'($urandom_range(0, 31)), $urandom());
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] e;
        fpu_result = 32'hDEAD_BEEF;
        issue(4'd0, 32'h3F80_0000, 32'h4000_0000, 5'd11);
        exp_q.push_back({1'b0, 5'd11, 32'h4040_0000});
        resp_ready = 1'b0;
        tick(); tick();
        fpu_result = 32'h4040_0000;
        tick();
        fpu_result = 32'hDEAD_BEEF;
        req_op = 4'd8; req_src0 = 32'h4000_0000; req_src1 = 32'h4000_0000; req_tag = 5'd12; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if ({m_resp_valid, m_req_ready, m_resp_illegal, m_resp_tag, m_resp_data} !== {2'b10, exp_q[0]}) begin
                n_err++; $display("FAIL stall_hold cyc=%0d: got %b %b %h expected 1 0 %h", i, m_resp_valid,
                                  m_req_ready, {m_resp_illegal, m_resp_tag, m_resp_data}, exp_q[0]);
            end
            tick();
        end
        n_vec++;
        if (m_fpu_op !== 4'd0) begin
            n_err++; $display("FAIL stall_no_accept: fpu_op got %h expected 0", m_fpu_op);
        end
        e = exp_q.pop_front();
        resp_ready = 1'b1;
        #1;
        n_vec++;
        if (m_req_ready !== 1'b1) begin
            n_err++; $display("FAIL b2b_ready: got %b expected 1", m_req_ready);
        end
        tick();
        req_valid = 1'b0;
        exp_q.push_back({1'b0, 5'd12, 32'h0000_0001});
        n_vec++;
        if ({m_resp_valid, m_fpu_op} !== {1'b0, 4'd8}) begin
            n_err++; $display("FAIL b2b_load: got %b %h expected 0 8", m_resp_valid, m_fpu_op);
        end
        fpu_result = 32'h0000_0001;
        tick();
        fpu_result = 32'hDEAD_BEEF;
        e = exp_q.pop_front();
        n_vec++;
        if ({m_resp_valid, m_resp_illegal, m_resp_tag, m_resp_data} !== {1'b1, e}) begin
            n_err++; $display("FAIL b2b_resp: got %b %h expected 1 %h", m_resp_valid,
                              {m_resp_illegal, m_resp_tag, m_resp_data}, e);
        end
        tick();
    endtask

    task automatic test_flush_exec();
        fpu_result = 32'hDEAD_BEEF;
        issue(4'd0, 32'h4100_0000, 32'h4100_0000, 5'd2);
        exp_q.push_back({1'b0, 5'd2, 32'h4180_0000});
        flush = 1'b1;
        tick();
        flush = 1'b0;
        void'(exp_q.pop_back());
        n_vec++;
        if ({m_busy, m_resp_valid} !== 2'b00) begin
            n_err++; $display("FAIL flush_exec_idle: got %b expected 00", {m_busy, m_resp_valid});
        end
        fpu_result = 32'h4180_0000;
        for (int i = 0; i < 6; i++) begin
            n_vec++;
            if (m_resp_valid !== 1'b0) begin
                n_err++; $display("FAIL flush_exec_noresp cyc=%0d: got %b expected 0", i, m_resp_valid);
            end
            tick();
        end
    endtask

    task automatic test_flush_done();
        fpu_result = 32'hDEAD_BEEF;
        issue(4'd1, 32'h4100_0000, 32'h3F80_0000, 5'd21);
        exp_q.push_back({1'b0, 5'd21, 32'h40E0_0000});
        resp_ready = 1'b0;
        tick(); tick();
        fpu_result = 32'h40E0_0000;
        tick();
        fpu_result = 32'hDEAD_BEEF;
        n_vec++;
        if (m_resp_valid !== 1'b1) begin
            n_err++; $display("FAIL flush_done_pre: got %b expected 1", m_resp_valid);
        end
        flush = 1'b1;
        req_op = 4'd8; req_src0 = 32'h1; req_src1 = 32'h2; req_tag = 5'd13; req_valid = 1'b1;
        #1;
        n_vec++;
        if (m_req_ready !== 1'b0) begin
            n_err++; $display("FAIL flush_done_ready: got %b expected 0", m_req_ready);
        end
        tick();
        flush = 1'b0;
        req_valid = 1'b0;
        void'(exp_q.pop_back());
        n_vec++;
        if ({m_busy, m_resp_valid, m_fpu_op} !== {2'b00, 4'd1}) begin
            n_err++; $display("FAIL flush_done_state: got %b %b %h expected 0 0 1", m_busy, m_resp_valid, m_fpu_op);
        end
        resp_ready = 1'b1;
        tick();
        n_vec++;
        if (m_resp_valid !== 1'b0) begin
            n_err++; $display("FAIL flush_done_noresp: got %b expected 0", m_resp_valid);
        end
    endtask

    task automatic test_div();
        logic [W-1:0] e;
        fpu_result = 32'h1234_5678;
        issue(4'd3, 32'h40C0_0000, 32'h4000_0000, 5'd9);
        exp_q.push_back({1'b1, 5'd9, 32'h0});
        exp_q.push_back({1'b0, 5'd9, 32'h4040_0000});
        e = exp_q.pop_front();
        n_vec++;
        if ({resp_valid_a, resp_illegal_a, resp_tag_a, resp_data_a} !== {1'b1, e}) begin
            n_err++; $display("FAIL div_nodiv_illegal: got %b %h expected 1 %h", resp_valid_a,
                              {resp_illegal_a, resp_tag_a, resp_data_a}, e);
        end
        fpu_result = 32'hDEAD_BEEF;
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if (resp_valid_b !== 1'b0) begin
                n_err++; $display("FAIL div_early_valid cyc=%0d: got %b expected 0", i, resp_valid_b);
            end
            if (i == 7) fpu_result = 32'h4040_0000;
            tick();
        end
        fpu_result = 32'hDEAD_BEEF;
        e = exp_q.pop_front();
        n_vec++;
        if ({resp_valid_b, resp_illegal_b, resp_tag_b, resp_data_b} !== {1'b1, e}) begin
            n_err++; $display("FAIL div_resp: got %b %h expected 1 %h", resp_valid_b,
                              {resp_illegal_b, resp_tag_b, resp_data_b}, e);
        end
        tick();
        n_vec++;
        if ({busy_a, busy_b} !== 2'b00) begin
            n_err++; $display("FAIL div_idle: got %b expected 00", {busy_a, busy_b});
        end
    endtask

    task automatic test_reset_mid();
        fpu_result = 32'hDEAD_BEEF;
        issue(4'd3, 32'h4120_0000, 32'h40A0_0000, 5'd4);
        tick(); tick();
        n_vec++;
        if ({busy_b, resp_valid_b} !== 2'b10) begin
            n_err++; $display("FAIL rstmid_pre: got %b expected 10", {busy_b, resp_valid_b});
        end
        rst = 1'b1;
        tick();
        n_vec++;
        if ({fpu_op_b, fpu_src0_b, fpu_src1_b, resp_valid_b, resp_data_b, resp_tag_b, resp_illegal_b, busy_b} !== '0) begin
            n_err++; $display("FAIL rstmid_outputs: got %h %h %h %b %h %h %b %b expected all 0", fpu_op_b,
                              fpu_src0_b, fpu_src1_b, resp_valid_b, resp_data_b, resp_tag_b, resp_illegal_b, busy_b);
        end
        rst = 1'b0;
        tick();
        chk_div = 1'b1;
        run_op(4'd5, 32'h4000_0000, 32'hC000_0000, 5'd6, 32'hC000_0000);
        chk_div = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fmul();
        test_patterns();
        test_illegal();
        test_random();
        test_back_to_back();
        test_flush_exec();
        test_flush_done();
        test_div();
        test_reset_mid();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
